// File: rtl/rail_sequencer.sv
// Power-rail sequencer: brings rails up in order with a per-rail pg debounce and
// timeout, and takes them down in reverse order at fixed spacing.
module rail_sequencer #(
    parameter int N_RAILS   = 5,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT   = 16000,
    parameter int SETTLE    = 400,
    parameter int OFF_DELAY = 400
) (
    input  logic               sysclk,
    input  logic               reset,
    input  logic               enable,
    input  logic [N_RAILS-1:0] pg,
    output logic [N_RAILS-1:0] rail_en,
    output logic               all_good,
    output logic               fault,
    output logic [2:0]         fault_rail,
    output logic [2:0]         state
);

    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_RAMP  = 3'd1,
        S_RUN   = 3'd2,
        S_SHUT  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] OD_LAST  = CNT_W'(OFF_DELAY - 1);
    localparam logic [2:0]       LAST_IDX = 3'(N_RAILS - 1);

    state_t             state_q, state_n;
    logic [N_RAILS-1:0] rail_en_n;
    logic               fault_n;
    logic [2:0]         fault_rail_n, idx_q, idx_n, idx_p1;
    logic [CNT_W-1:0]   timer_q, timer_n, timer_inc;
    logic [CNT_W-1:0]   settle_q, settle_n, settle_inc;
    logic               settled, low_found, any_found;
    logic [2:0]         low_idx, any_idx, hi_idx;

    assign timer_inc  = (&timer_q)  ? timer_q  : timer_q  + CNT_W'(1);
    assign settle_inc = (&settle_q) ? settle_q : settle_q + CNT_W'(1);
    assign settled    = pg[idx_q] && (settle_inc >= SETTLE_C);
    assign idx_p1     = idx_q + 3'd1;

    // Lowest dropped rail below idx (ramp) and over all rails (run); highest enabled rail.
    always_comb begin
        low_found = 1'b0;
        low_idx   = '0;
        any_found = 1'b0;
        any_idx   = '0;
        hi_idx    = '0;
        for (int j = N_RAILS - 1; j >= 0; j--) begin
            if (!pg[j] && (3'(j) < idx_q)) begin
                low_found = 1'b1;
                low_idx   = 3'(j);
            end
            if (!pg[j]) begin
                any_found = 1'b1;
                any_idx   = 3'(j);
            end
        end
        for (int j = 0; j < N_RAILS; j++)
            if (rail_en[j]) hi_idx = 3'(j);
    end

    always_comb begin
        logic go_shut;
        go_shut      = 1'b0;
        state_n      = state_q;
        rail_en_n    = rail_en;
        fault_n      = fault;
        fault_rail_n = fault_rail;
        idx_n        = idx_q;
        timer_n      = timer_inc;
        settle_n     = settle_q;
        case (state_q)
            S_OFF: begin
                rail_en_n = '0;
                idx_n     = '0;
                timer_n   = '0;
                settle_n  = '0;
                if (enable) begin
                    state_n   = S_RAMP;
                    rail_en_n = N_RAILS'(1);
                end
            end
            S_RAMP: begin
                settle_n = pg[idx_q] ? settle_inc : '0;
                if (low_found) begin
                    fault_n      = 1'b1;
                    fault_rail_n = low_idx;
                    go_shut      = 1'b1;
                end else if (settled) begin
                    if (!enable) begin
                        go_shut = 1'b1;
                    end else if (idx_q < LAST_IDX) begin
                        idx_n             = idx_p1;
                        rail_en_n[idx_p1] = 1'b1;
                        timer_n           = '0;
                        settle_n          = '0;
                    end else begin
                        state_n = S_RUN;
                    end
                end else if (timer_q >= TO_LAST) begin
                    fault_n      = 1'b1;
                    fault_rail_n = idx_q;
                    go_shut      = 1'b1;
                end else if (!enable) begin
                    go_shut = 1'b1;
                end
            end
            S_RUN: begin
                if (any_found) begin
                    fault_n      = 1'b1;
                    fault_rail_n = any_idx;
                    go_shut      = 1'b1;
                end else if (!enable) begin
                    go_shut = 1'b1;
                end
            end
            S_SHUT: begin
                if (timer_q >= OD_LAST) begin
                    rail_en_n[idx_q] = 1'b0;
                    timer_n          = '0;
                    if (idx_q == 3'd0) state_n = fault ? S_FAULT : S_OFF;
                    else               idx_n   = idx_q - 3'd1;
                end
            end
            S_FAULT: begin
                rail_en_n = '0;
                timer_n   = '0;
                if (!enable) begin
                    state_n = S_OFF;
                    fault_n = 1'b0;
                end
            end
            default: state_n = S_OFF;
        endcase
        if (go_shut) begin
            state_n  = S_SHUT;
            idx_n    = hi_idx;
            timer_n  = '0;
            settle_n = '0;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q    <= S_OFF;
            rail_en    <= '0;
            all_good   <= 1'b0;
            fault      <= 1'b0;
            fault_rail <= '0;
            idx_q      <= '0;
            timer_q    <= '0;
            settle_q   <= '0;
        end else begin
            state_q    <= state_n;
            rail_en    <= rail_en_n;
            all_good   <= (state_n == S_RUN);
            fault      <= fault_n;
            fault_rail <= fault_rail_n;
            idx_q      <= idx_n;
            timer_q    <= timer_n;
            settle_q   <= settle_n;
        end
    end

    assign state = state_q;

endmodule
